mu0_control: RTL and testbench
==============================

Name: mu0_control

Overview:
- Control unit for the 16-bit MU0 datapath. It sequences instruction fetch and execute, and drives every datapath select, enable and ALU-mode line.
- It issues memory read/write strobes and stalls on a memory-ready handshake.
- It sits beside the datapath in the MU0 top level. It consumes F, N and Z and produces X_sel, Y_sel, Addr_sel, PC_En, IR_En, Acc_En and M.

Parameters:
- None.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge
- Reset  input  1  synchronous, active-low reset (Reset=0 resets on next Clk edge)
- F  input  4  opcode, IR[15:12]
- N  input  1  Acc negative flag
- Z  input  1  Acc zero flag
- Mem_Ready  input  1  memory completes the current Rd/Wr access this cycle
- X_sel  output  1  0=Acc, 1=PC
- Y_sel  output  1  0=Din, 1=IR
- Addr_sel  output  1  0=PC, 1=IR[11:0]
- PC_En  output  1  PC load
- IR_En  output  1  IR load
- Acc_En  output  1  Acc load
- M  output  2  ALU mode: 00 Y, 01 X+Y, 10 X+1, 11 X-Y
- Rd  output  1  memory read strobe
- Wr  output  1  memory write strobe
- Fetch  output  1  1 while in FETCH
- Halted  output  1  1 while in HALT

Behaviour:
- States: FETCH, EXEC, HALT. State is held in a 2-bit register; encoding 11 is illegal and recovers to FETCH on the next edge.
- Outputs are combinational from state, F, N, Z and Mem_Ready. All outputs not listed for an action are 0.
- Reset=0 at an edge: state<=FETCH. While Reset=0, PC_En, IR_En, Acc_En, Rd and Wr are forced to 0. Halted=0.
- FETCH drives Addr_sel=0, Rd=1, X_sel=1, M=10. IR_En=PC_En=Mem_Ready.
  - Mem_Ready=1: go to EXEC.
  - Mem_Ready=0: remain in FETCH with selects and Rd held stable and all enables 0 (stall).
- EXEC decodes F:
  - 0 LDA: Addr_sel=1, Rd=1, Y_sel=0, M=00, Acc_En=Mem_Ready.
  - 1 STA: Addr_sel=1, X_sel=0, Wr=1. No enables.
  - 2 ADD: Addr_sel=1, Rd=1, X_sel=0, Y_sel=0, M=01, Acc_En=Mem_Ready.
  - 3 SUB: as ADD but M=11.
  - 4 JMP: Y_sel=1, M=00, PC_En=1. No memory access.
  - 5 JGE: as JMP when N=0; otherwise all enables 0.
  - 6 JNE: as JMP when Z=0; otherwise all enables 0.
  - 7 STP: go to HALT. No enables.
  - 8-15: no-operation, all enables 0.
- EXEC exit:
  - Memory opcodes (0-3) stay in EXEC until Mem_Ready=1, then go to FETCH.
  - Opcodes 4-6 and 8-15 return to FETCH in 1 cycle, ignoring Mem_Ready.
- N and Z are sampled combinationally in the EXEC cycle.
- HALT: Halted=1, all enables and strobes 0. Only Reset leaves HALT.
- Instruction latency with Mem_Ready tied high: memory and jump ops take 2 cycles; STP reaches HALT 2 cycles after FETCH begins.
- Reset asserted mid-stall or mid-EXEC aborts the access. Strobes drop in the same cycle, and FETCH is entered at the next edge.
- Rd and Wr are never both 1.

Optional Feature:
- MU0_CTRL_STEP_EN adds a single-step debug mode.
- When defined, the block adds ports Step (input 1) and Paused (output 1), and adds state PAUSE.
- After each EXEC completion that would enter FETCH, the FSM enters PAUSE instead.
- In PAUSE all enables and strobes are 0 and Paused=1.
- A rising edge on Step moves PAUSE to FETCH. Step is registered once; the edge is detected as Step & ~Step_q.
- A Step held high does not advance twice.
- Reset clears Step_q and the state goes to FETCH.
- When undefined, there are no Step or Paused ports and no PAUSE state; behaviour is exactly as above.

Test Plan:
- Reset=0 for 2 cycles, then 1 with Mem_Ready=1 -> Fetch=1, Rd=1, Addr_sel=0, M=10, IR_En=PC_En=1 in the first cycle; EXEC in the next cycle.
- F=0 (LDA), Mem_Ready held 0 for 3 EXEC cycles then 1 -> Rd=1 and Addr_sel=1 stable; Acc_En=0 for 3 cycles, Acc_En=1 in the 4th; FETCH follows.
- F=5 with N=1, then F=5 with N=0 -> PC_En=0 in the first case, PC_En=1, Y_sel=1, M=00 in the second; FETCH next in both.
- F=1 (STA), Mem_Ready=1 -> Wr=1, Rd=0, X_sel=0, Addr_sel=1, all enables 0; then FETCH.
- F=7 (STP) -> Halted=1 from the next cycle; stays 1 for 10 cycles with Mem_Ready toggling; Reset=0 -> Fetch=1, Halted=0.
- MU0_CTRL_STEP_EN: run F=4 -> Paused=1 after EXEC; Step held high 5 cycles -> exactly one FETCH, then Paused=1 again.

Source files
------------

// File: rtl/mu0_control.sv
// -----------------------------------------------------------------------------
// mu0_control
//   Control unit for the 16-bit MU0 datapath. Sequences instruction fetch and
//   execute, drives every datapath select/enable line and the ALU mode, issues
//   memory read/write strobes and stalls on the Mem_Ready handshake.
//
// Ports:
//   Clk        in   system clock, all state updates on the rising edge
//   Reset      in   synchronous active-low reset
//   F[3:0]     in   opcode, IR[15:12]
//   N, Z       in   Acc negative / zero flags, sampled in the EXEC cycle
//   Mem_Ready  in   memory completes the current Rd/Wr access this cycle
//   Step       in   single-step advance (only with MU0_CTRL_STEP_EN)
//   X_sel      out  ALU X operand: 0=Acc, 1=PC
//   Y_sel      out  ALU Y operand: 0=Din, 1=IR
//   Addr_sel   out  memory address: 0=PC, 1=IR[11:0]
//   PC_En      out  PC load
//   IR_En      out  IR load
//   Acc_En     out  Acc load
//   M[1:0]     out  ALU mode: 00 Y, 01 X+Y, 10 X+1, 11 X-Y
//   Rd, Wr     out  memory read / write strobes (never both high)
//   Fetch      out  1 while in FETCH
//   Paused     out  1 while in PAUSE (only with MU0_CTRL_STEP_EN)
//   Halted     out  1 while in HALT
//
// Build option:
//   MU0_CTRL_STEP_EN  adds the single-step debug mode: after every completed
//                     instruction the FSM parks in PAUSE until a rising edge
//                     on Step.
// -----------------------------------------------------------------------------
`default_nettype none

module mu0_control (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [3:0] F,
    input  logic       N,
    input  logic       Z,
    input  logic       Mem_Ready,
`ifdef MU0_CTRL_STEP_EN
    input  logic       Step,
    output logic       Paused,
`endif
    output logic       X_sel,
    output logic       Y_sel,
    output logic       Addr_sel,
    output logic       PC_En,
    output logic       IR_En,
    output logic       Acc_En,
    output logic [1:0] M,
    output logic       Rd,
    output logic       Wr,
    output logic       Fetch,
    output logic       Halted
);

    // Encoding 2'b11 is PAUSE in the stepping build and illegal otherwise;
    // the illegal code falls into the next-state default and recovers to FETCH.
    typedef enum logic [1:0] {
        S_FETCH = 2'b00,
        S_EXEC  = 2'b01,
        S_HALT  = 2'b10
`ifdef MU0_CTRL_STEP_EN
        ,
        S_PAUSE = 2'b11
`endif
    } state_t;

    localparam logic [1:0] M_Y    = 2'b00;
    localparam logic [1:0] M_ADD  = 2'b01;
    localparam logic [1:0] M_INC  = 2'b10;
    localparam logic [1:0] M_SUB  = 2'b11;

    localparam logic [3:0] OP_LDA = 4'd0;
    localparam logic [3:0] OP_STA = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_JMP = 4'd4;
    localparam logic [3:0] OP_JGE = 4'd5;
    localparam logic [3:0] OP_JNE = 4'd6;
    localparam logic [3:0] OP_STP = 4'd7;

    state_t state;
    state_t next_state;
    state_t done_state;     // where a completed instruction goes
    logic   is_mem_op;      // opcodes 0-3 wait for Mem_Ready in EXEC

    assign is_mem_op = (F[3:2] == 2'b00);

`ifdef MU0_CTRL_STEP_EN
    logic step_q;
    logic step_rise;

    assign step_rise  = Step & ~step_q;
    assign done_state = S_PAUSE;

    always_ff @(posedge Clk) begin
        if (!Reset) step_q <= 1'b0;
        else        step_q <= Step;
    end
`else
    assign done_state = S_FETCH;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so
    // every flop samples the pre-edge values, independent of block order.
    always_ff @(posedge Clk) begin
        if (!Reset) state <= S_FETCH;
        else        state <= next_state;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH: next_state = Mem_Ready ? S_EXEC : S_FETCH;
            S_EXEC: begin
                if (is_mem_op)          next_state = Mem_Ready ? done_state : S_EXEC;
                else if (F == OP_STP)   next_state = S_HALT;
                else                    next_state = done_state;
            end
            S_HALT:  next_state = S_HALT;
`ifdef MU0_CTRL_STEP_EN
            S_PAUSE: next_state = step_rise ? S_FETCH : S_PAUSE;
`endif
            default: next_state = S_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        X_sel    = 1'b0;
        Y_sel    = 1'b0;
        Addr_sel = 1'b0;
        PC_En    = 1'b0;
        IR_En    = 1'b0;
        Acc_En   = 1'b0;
        M        = M_Y;
        Rd       = 1'b0;
        Wr       = 1'b0;
        Fetch    = 1'b0;
        Halted   = 1'b0;
`ifdef MU0_CTRL_STEP_EN
        Paused   = 1'b0;
`endif

        case (state)
            S_FETCH: begin
                // Selects and Rd stay stable while stalled; enables only
                // fire in the cycle the memory delivers the instruction.
                Fetch    = 1'b1;
                Addr_sel = 1'b0;
                Rd       = 1'b1;
                X_sel    = 1'b1;
                M        = M_INC;
                IR_En    = Mem_Ready;
                PC_En    = Mem_Ready;
            end
            S_EXEC: begin
                case (F)
                    OP_LDA: begin
                        Addr_sel = 1'b1;
                        Rd       = 1'b1;
                        M        = M_Y;
                        Acc_En   = Mem_Ready;
                    end
                    OP_STA: begin
                        Addr_sel = 1'b1;
                        Wr       = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        Addr_sel = 1'b1;
                        Rd       = 1'b1;
                        M        = (F == OP_ADD) ? M_ADD : M_SUB;
                        Acc_En   = Mem_Ready;
                    end
                    OP_JMP, OP_JGE, OP_JNE: begin
                        // Jump target comes from IR through the Y path.
                        Y_sel = 1'b1;
                        M     = M_Y;
                        case (F)
                            OP_JGE:  PC_En = ~N;
                            OP_JNE:  PC_En = ~Z;
                            default: PC_En = 1'b1;
                        endcase
                    end
                    default: ;  // STP and 8-15: nothing enabled
                endcase
            end
            S_HALT: Halted = 1'b1;
`ifdef MU0_CTRL_STEP_EN
            S_PAUSE: Paused = 1'b1;
`endif
            default: ;
        endcase

        // Reset aborts any access immediately, not at the next edge.
        if (!Reset) begin
            PC_En  = 1'b0;
            IR_En  = 1'b0;
            Acc_En = 1'b0;
            Rd     = 1'b0;
            Wr     = 1'b0;
            Halted = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mu0_control.sv
// -----------------------------------------------------------------------------
// tb_mu0_control
//   Directed testbench for mu0_control. Inputs change 1 time unit after the
//   rising edge; outputs are compared 1 time unit after that, well before the
//   next edge. The whole output set is compared as one packed vector:
//   {Fetch,Halted,Rd,Wr,X_sel,Y_sel,Addr_sel,PC_En,IR_En,Acc_En,M[1:0]}
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mu0_control;

    logic       Clk;
    logic       Reset;
    logic [3:0] F;
    logic       N;
    logic       Z;
    logic       Mem_Ready;
    logic       X_sel, Y_sel, Addr_sel, PC_En, IR_En, Acc_En;
    logic [1:0] M;
    logic       Rd, Wr, Fetch, Halted;
`ifdef MU0_CTRL_STEP_EN
    logic       Step;
    logic       Paused;
`endif

    int errors = 0;
    int checks = 0;

    logic [11:0] outs;
    assign outs = {Fetch, Halted, Rd, Wr, X_sel, Y_sel, Addr_sel,
                   PC_En, IR_En, Acc_En, M};

    // Expected output vectors, fields in the order of 'outs'.
    localparam logic [11:0] V_FETCH_GO   = 12'b1_0_1_0_1_0_0_1_1_0_10;
    localparam logic [11:0] V_FETCH_WAIT = 12'b1_0_1_0_1_0_0_0_0_0_10;
    localparam logic [11:0] V_FETCH_RST  = 12'b1_0_0_0_1_0_0_0_0_0_10;
    localparam logic [11:0] V_LDA_WAIT   = 12'b0_0_1_0_0_0_1_0_0_0_00;
    localparam logic [11:0] V_LDA_GO     = 12'b0_0_1_0_0_0_1_0_0_1_00;
    localparam logic [11:0] V_LDA_RST    = 12'b0_0_0_0_0_0_1_0_0_0_00;
    localparam logic [11:0] V_STA        = 12'b0_0_0_1_0_0_1_0_0_0_00;
    localparam logic [11:0] V_ADD_GO     = 12'b0_0_1_0_0_0_1_0_0_1_01;
    localparam logic [11:0] V_ADD_WAIT   = 12'b0_0_1_0_0_0_1_0_0_0_01;
    localparam logic [11:0] V_SUB_GO     = 12'b0_0_1_0_0_0_1_0_0_1_11;
    localparam logic [11:0] V_JMP        = 12'b0_0_0_0_0_1_0_1_0_0_00;
    localparam logic [11:0] V_IDLE       = 12'b0_0_0_0_0_0_0_0_0_0_00;
    localparam logic [11:0] V_HALT       = 12'b0_1_0_0_0_0_0_0_0_0_00;

    mu0_control dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .F         (F),
        .N         (N),
        .Z         (Z),
        .Mem_Ready (Mem_Ready),
`ifdef MU0_CTRL_STEP_EN
        .Step      (Step),
        .Paused    (Paused),
`endif
        .X_sel     (X_sel),
        .Y_sel     (Y_sel),
        .Addr_sel  (Addr_sel),
        .PC_En     (PC_En),
        .IR_En     (IR_En),
        .Acc_En    (Acc_En),
        .M         (M),
        .Rd        (Rd),
        .Wr        (Wr),
        .Fetch     (Fetch),
        .Halted    (Halted)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Advance one clock; return 1ns after the rising edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Clock edge that completes an EXEC. In the stepping build that lands in
    // PAUSE, so a Step pulse is issued to come back to FETCH.
    task automatic exec_edge();
        tick();
`ifdef MU0_CTRL_STEP_EN
        Step = 1'b1;
        tick();
        Step = 1'b0;
`endif
    endtask

    task automatic test_reset();
        Reset = 1'b0; Mem_Ready = 1'b1; F = 4'd8; N = 1'b0; Z = 1'b0;
`ifdef MU0_CTRL_STEP_EN
        Step = 1'b0;
`endif
        tick();
        #1;
        checks++;
        if (outs !== V_FETCH_RST) begin
            errors++;
            $display("FAIL reset_hold: got %b want %b", outs, V_FETCH_RST);
        end
        tick();
        Reset = 1'b1;
        #1;
        checks++;
        if (outs !== V_FETCH_GO) begin
            errors++;
            $display("FAIL reset_first_fetch: got %b want %b", outs, V_FETCH_GO);
        end
        tick();
        #1;
        checks++;
        if (outs !== V_IDLE) begin
            errors++;
            $display("FAIL reset_exec_nop: got %b want %b", outs, V_IDLE);
        end
        exec_edge();
    endtask

    task automatic test_lda_stall();
        F = 4'd0; Mem_Ready = 1'b1;
        #1;
        checks++;
        if (outs !== V_FETCH_GO) begin
            errors++;
            $display("FAIL lda_fetch: got %b want %b", outs, V_FETCH_GO);
        end
        tick();
        Mem_Ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (outs !== V_LDA_WAIT) begin
                errors++;
                $display("FAIL lda_stall_%0d: got %b want %b", i, outs, V_LDA_WAIT);
            end
            tick();
        end
        Mem_Ready = 1'b1;
        #1;
        checks++;
        if (outs !== V_LDA_GO) begin
            errors++;
            $display("FAIL lda_done: got %b want %b", outs, V_LDA_GO);
        end
        exec_edge();
        #1;
        checks++;
        if (outs !== V_FETCH_GO) begin
            errors++;
            $display("FAIL lda_next_fetch: got %b want %b", outs, V_FETCH_GO);
        end
    endtask

    task automatic test_fetch_stall();
        Mem_Ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (outs !== V_FETCH_WAIT) begin
                errors++;
                $display("FAIL fetch_stall_%0d: got %b want %b", i, outs, V_FETCH_WAIT);
            end
            tick();
        end
        Mem_Ready = 1'b1;
    endtask

    task automatic test_jge();
        F = 4'd5; N = 1'b1; Mem_Ready = 1'b1;
        tick();
        #1;
        checks++;
        if (PC_En !== 1'b0) begin
            errors++;
            $display("FAIL jge_n1_pc_en: got %b want 0", PC_En);
        end
        exec_edge();
        #1;
        checks++;
        if (Fetch !== 1'b1) begin
            errors++;
            $display("FAIL jge_n1_next_fetch: got %b want 1", Fetch);
        end
        N = 1'b0;
        tick();
        #1;
        checks++;
        if (outs !== V_JMP) begin
            errors++;
            $display("FAIL jge_n0_taken: got %b want %b", outs, V_JMP);
        end
        exec_edge();
        #1;
        checks++;
        if (Fetch !== 1'b1) begin
            errors++;
            $display("FAIL jge_n0_next_fetch: got %b want 1", Fetch);
        end
    endtask

    task automatic test_jne();
        F = 4'd6; Z = 1'b1; Mem_Ready = 1'b0;
        Mem_Ready = 1'b1;
        tick();
        Mem_Ready = 1'b0;   // jumps ignore Mem_Ready
        #1;
        checks++;
        if (PC_En !== 1'b0) begin
            errors++;
            $display("FAIL jne_z1_pc_en: got %b want 0", PC_En);
        end
        exec_edge();
        Mem_Ready = 1'b1;
        #1;
        checks++;
        if (Fetch !== 1'b1) begin
            errors++;
            $display("FAIL jne_z1_next_fetch: got %b want 1", Fetch);
        end
        Z = 1'b0;
        tick();
        #1;
        checks++;
        if (outs !== V_JMP) begin
            errors++;
            $display("FAIL jne_z0_taken: got %b want %b", outs, V_JMP);
        end
        exec_edge();
    endtask

    task automatic test_sta();
        F = 4'd1; Mem_Ready = 1'b1;
        tick();
        #1;
        checks++;
        if (outs !== V_STA) begin
            errors++;
            $display("FAIL sta_exec: got %b want %b", outs, V_STA);
        end
        exec_edge();
        #1;
        checks++;
        if (Fetch !== 1'b1) begin
            errors++;
            $display("FAIL sta_next_fetch: got %b want 1", Fetch);
        end
    endtask

    task automatic test_alu();
        F = 4'd2; Mem_Ready = 1'b1;
        tick();
        Mem_Ready = 1'b0;
        #1;
        checks++;
        if (outs !== V_ADD_WAIT) begin
            errors++;
            $display("FAIL add_stall: got %b want %b", outs, V_ADD_WAIT);
        end
        tick();
        Mem_Ready = 1'b1;
        #1;
        checks++;
        if (outs !== V_ADD_GO) begin
            errors++;
            $display("FAIL add_done: got %b want %b", outs, V_ADD_GO);
        end
        exec_edge();
        F = 4'd3;
        tick();
        #1;
        checks++;
        if (outs !== V_SUB_GO) begin
            errors++;
            $display("FAIL sub_done: got %b want %b", outs, V_SUB_GO);
        end
        exec_edge();
        F = 4'd12;
        tick();
        #1;
        checks++;
        if (outs !== V_IDLE) begin
            errors++;
            $display("FAIL nop_exec: got %b want %b", outs, V_IDLE);
        end
        exec_edge();
        #1;
        checks++;
        if (Fetch !== 1'b1) begin
            errors++;
            $display("FAIL nop_next_fetch: got %b want 1", Fetch);
        end
    endtask

    task automatic test_reset_abort();
        F = 4'd0; Mem_Ready = 1'b1;
        tick();
        Mem_Ready = 1'b0;
        #1;
        checks++;
        if (outs !== V_LDA_WAIT) begin
            errors++;
            $display("FAIL abort_pre: got %b want %b", outs, V_LDA_WAIT);
        end
        Reset = 1'b0;
        #1;
        checks++;
        if (outs !== V_LDA_RST) begin
            errors++;
            $display("FAIL abort_strobe_drop: got %b want %b", outs, V_LDA_RST);
        end
        tick();
        #1;
        checks++;
        if (outs !== V_FETCH_RST) begin
            errors++;
            $display("FAIL abort_to_fetch: got %b want %b", outs, V_FETCH_RST);
        end
        Reset = 1'b1;
        Mem_Ready = 1'b1;
    endtask

    task automatic test_stp();
        F = 4'd7; Mem_Ready = 1'b1;
        tick();
        #1;
        checks++;
        if (outs !== V_IDLE) begin
            errors++;
            $display("FAIL stp_exec: got %b want %b", outs, V_IDLE);
        end
        tick();
        for (int i = 0; i < 10; i++) begin
            Mem_Ready = i[0];
            F = 4'(i);
            #1;
            checks++;
            if (outs !== V_HALT) begin
                errors++;
                $display("FAIL halt_hold_%0d: got %b want %b", i, outs, V_HALT);
            end
            tick();
        end
        Reset = 1'b0; F = 4'd8;
        tick();
        Reset = 1'b1; Mem_Ready = 1'b1;
        #1;
        checks++;
        if (outs !== V_FETCH_GO) begin
            errors++;
            $display("FAIL halt_reset_fetch: got %b want %b", outs, V_FETCH_GO);
        end
    endtask

`ifdef MU0_CTRL_STEP_EN
    task automatic test_step();
        int fetches;
        F = 4'd4; Mem_Ready = 1'b1; Step = 1'b0;
        tick();
        #1;
        checks++;
        if (outs !== V_JMP || Paused !== 1'b0) begin
            errors++;
            $display("FAIL step_exec: got %b/%b want %b/0", outs, Paused, V_JMP);
        end
        tick();
        #1;
        checks++;
        if (Paused !== 1'b1 || outs !== V_IDLE) begin
            errors++;
            $display("FAIL step_paused: got %b/%b want %b/1", outs, Paused, V_IDLE);
        end
        Step = 1'b1;
        fetches = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            #1;
            if (Fetch === 1'b1) fetches++;
        end
        checks++;
        if (fetches !== 1) begin
            errors++;
            $display("FAIL step_single_fetch: got %0d want 1", fetches);
        end
        checks++;
        if (Paused !== 1'b1) begin
            errors++;
            $display("FAIL step_repaused: got %b want 1", Paused);
        end
        Step = 1'b0;
        tick();
        Step = 1'b1;
        tick();
        Step = 1'b0;
        #1;
        checks++;
        if (Fetch !== 1'b1) begin
            errors++;
            $display("FAIL step_resume: got %b want 1", Fetch);
        end
    endtask
`endif

    initial begin
        Reset = 1'b0; F = 4'd0; N = 1'b0; Z = 1'b0; Mem_Ready = 1'b0;
`ifdef MU0_CTRL_STEP_EN
        Step = 1'b0;
`endif
        test_reset();
        test_lda_stall();
        test_fetch_stall();
        test_jge();
        test_jne();
        test_sta();
        test_alu();
        test_reset_abort();
        test_stp();
`ifdef MU0_CTRL_STEP_EN
        test_step();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
